// File: rtl/merge.sv
// Controlled two-way merge: a control token on C picks whether A or B supplies
// the next data token, which lands in a single registered output stage R.
module merge #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A_data,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic [WIDTH-1:0] B_data,
  input  logic             B_valid,
  output logic             B_ready,
  input  logic             C_data,
  input  logic             C_valid,
  output logic             C_ready,
  output logic [WIDTH-1:0] R_data,
  output logic             R_valid,
  input  logic             R_ready
);

  // Handshake: a transfer happens on a channel in any cycle where its valid and
  // ready are both high at the rising edge. A valid never waits on its ready.
  // Readies here depend combinationally on the valids and on R_ready.

  logic [WIDTH-1:0] r_state;
  logic             r_valid;

  logic w_space;
  logic w_take0;
  logic w_take1;

  // The output slot can accept a token if it is empty or is being drained now.
  assign w_space = !r_valid || R_ready;

  // Control and selected data are consumed together or not at all.
  assign w_take0 = !reset && C_valid && (C_data == 1'b0) && A_valid && w_space;
  assign w_take1 = !reset && C_valid && (C_data == 1'b1) && B_valid && w_space;

  assign A_ready = w_take0;
  assign B_ready = w_take1;
  assign C_ready = w_take0 || w_take1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= '0;
      r_valid <= 1'b0;
    end else if (w_take0) begin
      r_state <= A_data;
      r_valid <= 1'b1;
    end else if (w_take1) begin
      r_state <= B_data;
      r_valid <= 1'b1;
    end else if (R_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign R_data  = r_state;
  assign R_valid = r_valid;

endmodule

// File: tb/tb_merge.sv
// Directed scoreboard bench for merge: the driver pushes expected R tokens,
// a negedge monitor pops and compares whenever R transfers.
module tb_merge;
  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [W-1:0] A_data;
  logic         A_valid;
  logic         A_ready;
  logic [W-1:0] B_data;
  logic         B_valid;
  logic         B_ready;
  logic         C_data;
  logic         C_valid;
  logic         C_ready;
  logic [W-1:0] R_data;
  logic         R_valid;
  logic         R_ready;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  merge #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready),
    .C_data(C_data), .C_valid(C_valid), .C_ready(C_ready),
    .R_data(R_data), .R_valid(R_valid), .R_ready(R_ready)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor: an R transfer is sampled mid-cycle before its edge
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (!reset && R_valid === 1'b1 && R_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL r_token: got %0h with no token expected", R_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (R_data !== exp_v) begin
          errors++;
          $display("FAIL r_token: got %0h exp %0h", R_data, exp_v);
        end
      end
    end
  end

  // driver task: apply one cycle of inputs, check readies and R_valid
  // (and optionally R_data) mid-cycle, push any token expected to be taken.
  task automatic cycle(input logic [W-1:0] a_d, input logic a_v,
                       input logic [W-1:0] b_d, input logic b_v,
                       input logic c_d, input logic c_v, input logic r_rdy,
                       input logic [2:0] exp_rdy, input logic exp_rv,
                       input logic chk_rd, input logic [W-1:0] exp_rd);
    logic [2:0] got_rdy;
    A_data = a_d; A_valid = a_v;
    B_data = b_d; B_valid = b_v;
    C_data = c_d; C_valid = c_v;
    R_ready = r_rdy;
    @(negedge clk);
    got_rdy = {A_ready, B_ready, C_ready};
    checks++;
    if (got_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL readies(A,B,C): got %b exp %b at %0t", got_rdy, exp_rdy, $time);
    end
    checks++;
    if (R_valid !== exp_rv) begin
      errors++;
      $display("FAIL r_valid: got %b exp %b at %0t", R_valid, exp_rv, $time);
    end
    if (chk_rd) begin
      checks++;
      if (R_data !== exp_rd) begin
        errors++;
        $display("FAIL r_data: got %0h exp %0h at %0t", R_data, exp_rd, $time);
      end
    end
    if (exp_rdy[2]) exp_q.push_back(a_d);
    if (exp_rdy[1]) exp_q.push_back(b_d);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    A_data = '0; A_valid = 1'b0;
    B_data = '0; B_valid = 1'b0;
    C_data = 1'b0; C_valid = 1'b0;
    R_ready = 1'b0;

    // 1: reset held two cycles with every valid high
    cycle(64'h11, 1, 64'h22, 1, 1'b0, 1, 1, 3'b000, 0, 1, 64'h0);
    cycle(64'h11, 1, 64'h22, 1, 1'b1, 1, 1, 3'b000, 0, 1, 64'h0);
    reset = 1'b0;

    // 2: C=0 with A and B both valid; only A taken, B left pending
    cycle(64'h11, 1, 64'h22, 1, 1'b0, 1, 1, 3'b101, 0, 0, 64'h0);
    cycle(64'h11, 0, 64'h22, 1, 1'b0, 0, 0, 3'b000, 1, 1, 64'h11);
    cycle(64'h11, 0, 64'h22, 1, 1'b0, 0, 1, 3'b000, 1, 1, 64'h11);

    // 3: C stream 0,1,1,0 at full rate
    cycle(64'hA0, 1, 64'hB0, 1, 1'b0, 1, 1, 3'b101, 0, 0, 64'h0);
    cycle(64'hA1, 1, 64'hB0, 1, 1'b1, 1, 1, 3'b011, 1, 1, 64'hA0);
    cycle(64'hA1, 1, 64'hB1, 1, 1'b1, 1, 1, 3'b011, 1, 1, 64'hB0);
    cycle(64'hA1, 1, 64'hB1, 0, 1'b0, 1, 1, 3'b101, 1, 1, 64'hB1);

    // 4: load 0x5, stall three cycles, then accept with a same-cycle take
    cycle(64'h5, 1, 64'h0, 0, 1'b0, 1, 1, 3'b101, 1, 1, 64'hA1);
    cycle(64'h6, 1, 64'h0, 0, 1'b0, 1, 0, 3'b000, 1, 1, 64'h5);
    cycle(64'h6, 1, 64'h0, 0, 1'b0, 1, 0, 3'b000, 1, 1, 64'h5);
    cycle(64'h6, 1, 64'h0, 0, 1'b0, 1, 0, 3'b000, 1, 1, 64'h5);
    cycle(64'h6, 1, 64'h0, 0, 1'b0, 1, 1, 3'b101, 1, 1, 64'h5);

    // 5: C selects B but B absent for four cycles; R drains meanwhile
    cycle(64'h77, 1, 64'h88, 0, 1'b1, 1, 1, 3'b000, 1, 1, 64'h6);
    cycle(64'h77, 1, 64'h88, 0, 1'b1, 1, 1, 3'b000, 0, 0, 64'h0);
    cycle(64'h77, 1, 64'h88, 0, 1'b1, 1, 1, 3'b000, 0, 0, 64'h0);
    cycle(64'h77, 1, 64'h88, 0, 1'b1, 1, 1, 3'b000, 0, 0, 64'h0);
    cycle(64'h77, 1, 64'h88, 1, 1'b1, 1, 1, 3'b011, 0, 0, 64'h0);

    // data valid without control: nothing moves
    cycle(64'h78, 1, 64'h89, 1, 1'b0, 0, 1, 3'b000, 1, 1, 64'h88);

    // 6: load 0x7, hold it, then reset mid-stream drops it
    cycle(64'h78, 0, 64'h7, 1, 1'b1, 1, 1, 3'b011, 0, 0, 64'h0);
    cycle(64'h99, 1, 64'h9A, 1, 1'b0, 1, 0, 3'b000, 1, 1, 64'h7);
    exp_q.delete();
    reset = 1'b1;
    cycle(64'h99, 1, 64'h9A, 1, 1'b0, 1, 0, 3'b000, 1, 1, 64'h7);
    cycle(64'h99, 1, 64'h9A, 1, 1'b1, 1, 0, 3'b000, 0, 1, 64'h0);
    reset = 1'b0;
    cycle(64'h0, 0, 64'h0, 0, 1'b0, 0, 1, 3'b000, 0, 1, 64'h0);

    // after reset, the pending A token still transfers normally
    cycle(64'h99, 1, 64'h9A, 1, 1'b0, 1, 1, 3'b101, 0, 0, 64'h0);
    cycle(64'h0, 0, 64'h0, 0, 1'b0, 0, 1, 3'b000, 1, 1, 64'h99);
    cycle(64'h0, 0, 64'h0, 0, 1'b0, 0, 1, 3'b000, 0, 0, 64'h0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d tokens left exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
